// File: rtl/sd_dma_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sd_dma_arbiter
// Purpose  : Round-robin arbiter sharing one host SD block channel between
//            NREQ block-device requesters, with ack/strobe routing and CPU stall.
// Revision : 1.0 - initial release
// ============================================================================
module sd_dma_arbiter #(
    parameter int               NREQ      = 3,
    parameter logic [NREQ-1:0]  WAIT_MASK = 3'b010,
    parameter logic [23:0]      TIMEOUT   = 24'd1000000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_rd,
    input  logic [NREQ-1:0]      req_wr,
    input  logic [32*NREQ-1:0]   req_lba,
    output logic [NREQ-1:0]      req_ack,
    output logic [NREQ-1:0]      req_buff_wr,
    output logic [NREQ-1:0]      req_done,
    output logic [NREQ-1:0]      req_err,
    output logic [NREQ-1:0]      grant,
    output logic [31:0]          host_lba,
    output logic                 host_rd,
    output logic                 host_wr,
    input  logic                 host_ack,
    input  logic                 host_buff_wr,
    output logic                 busy,
    output logic                 cpu_wait
);

    localparam int c_IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_XFER = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state, w_state;
    logic [NREQ-1:0]   r_pend_rd, r_pend_wr, w_pend_rd, w_pend_wr;
    logic [NREQ-1:0]   w_clr_rd, w_clr_wr;
    logic [c_IW-1:0]   r_rr_last, w_rr_last;
    logic [c_IW-1:0]   r_gidx, w_gidx;
    logic [NREQ-1:0]   r_grant, w_grant;
    logic [31:0]       r_lba, w_lba;
    logic              r_rd, w_rd, r_wr, w_wr, r_is_wr, w_is_wr;
    logic [NREQ-1:0]   r_err, w_err;
    logic [23:0]       r_cnt, w_cnt;

    logic [NREQ-1:0]   w_pend_any;
    logic              w_found;
    logic [c_IW-1:0]   w_win, w_idx;

    // Round-robin search starting just after the last serviced requester
    always_comb begin
        w_pend_any = r_pend_rd | r_pend_wr;
        w_found    = 1'b0;
        w_win      = '0;
        w_idx      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = c_IW'((int'(r_rr_last) + k) % NREQ);
            if (!w_found && w_pend_any[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_comb begin
        w_state   = r_state;
        w_grant   = r_grant;
        w_gidx    = r_gidx;
        w_lba     = r_lba;
        w_rd      = r_rd;
        w_wr      = r_wr;
        w_is_wr   = r_is_wr;
        w_cnt     = r_cnt;
        w_rr_last = r_rr_last;
        w_err     = '0;
        w_clr_rd  = '0;
        w_clr_wr  = '0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_gidx  = w_win;
                    w_grant = NREQ'(1) << w_win;
                    w_lba   = req_lba[{w_win, 5'b0} +: 32];
                    w_is_wr = r_pend_wr[w_win];
                    w_wr    = r_pend_wr[w_win];
                    w_rd    = ~r_pend_wr[w_win];
                    w_cnt   = '0;
                    w_state = S_REQ;
                end
            end
            S_REQ: begin
                if (host_ack) begin
                    w_rd    = 1'b0;
                    w_wr    = 1'b0;
                    if (r_is_wr) w_clr_wr = r_grant;
                    else         w_clr_rd = r_grant;
                    w_state = S_XFER;
                end else if ((TIMEOUT != 24'd0) && (r_cnt == TIMEOUT - 24'd1)) begin
                    w_rd      = 1'b0;
                    w_wr      = 1'b0;
                    if (r_is_wr) w_clr_wr = r_grant;
                    else         w_clr_rd = r_grant;
                    w_err     = r_grant;
                    w_grant   = '0;
                    w_rr_last = r_gidx;
                    w_state   = S_IDLE;
                end else begin
                    w_cnt = r_cnt + 24'd1;
                end
            end
            S_XFER: begin
                if (!host_ack) w_state = S_DONE;
            end
            S_DONE: begin
                w_rr_last = r_gidx;
                w_grant   = '0;
                w_state   = S_IDLE;
            end
            default: w_state = S_IDLE;
        endcase
        // A new request in the same cycle as a clear keeps the bit set
        w_pend_rd = (r_pend_rd & ~w_clr_rd) | req_rd;
        w_pend_wr = (r_pend_wr & ~w_clr_wr) | req_wr;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_pend_rd <= '0;
            r_pend_wr <= '0;
            r_rr_last <= c_IW'(NREQ - 1);
            r_gidx    <= '0;
            r_grant   <= '0;
            r_lba     <= '0;
            r_rd      <= 1'b0;
            r_wr      <= 1'b0;
            r_is_wr   <= 1'b0;
            r_err     <= '0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state;
            r_pend_rd <= w_pend_rd;
            r_pend_wr <= w_pend_wr;
            r_rr_last <= w_rr_last;
            r_gidx    <= w_gidx;
            r_grant   <= w_grant;
            r_lba     <= w_lba;
            r_rd      <= w_rd;
            r_wr      <= w_wr;
            r_is_wr   <= w_is_wr;
            r_err     <= w_err;
            r_cnt     <= w_cnt;
        end
    end

    assign grant       = r_grant;
    assign host_lba    = r_lba;
    assign host_rd     = r_rd;
    assign host_wr     = r_wr;
    assign req_err     = r_err;
    assign busy        = (r_state != S_IDLE);
    assign req_ack     = (r_state != S_IDLE) ? (r_grant & {NREQ{host_ack}}) : '0;
    assign req_buff_wr = (r_state == S_XFER) ? (r_grant & {NREQ{host_buff_wr}}) : '0;
    assign req_done    = (r_state == S_DONE) ? r_grant : '0;
    assign cpu_wait    = |(WAIT_MASK & (r_pend_rd | r_pend_wr | r_grant));

endmodule
`default_nettype wire
